// File: rtl/mux4_arbiter_if.sv
// Request/grant bundle between four requesters and the mux4 arbiter.
// The arbiter takes the slave side; requesters (or a bench) take the master side.
interface mux4_arbiter_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] select;
  logic       valid;

  modport master (output req, input grant, select, valid);
  modport slave  (input req, output grant, select, valid);
endinterface

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter steering the shared mux4 select among four requesters.
// Define MUX4_ARB_TIMEOUT_EN to compile in the MAX_HOLD forced-rotation counter.
module mux4_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mux4_arbiter_if.slave   bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_hold
    $error("mux4_arbiter: MAX_HOLD out of range 2..256");
  end

  typedef enum logic {IDLE, OWN} state_e;

  state_e     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic [3:0] owner_oh, others;
  logic [1:0] win_any, win_oth;

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // First set bit scanning from last+1, wrapping; last itself is checked last.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] last);
    logic       found;
    logic [1:0] idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (r[idx] && !found) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign owner_oh = 4'b0001 << last_q;
  assign others   = bus.req & ~owner_oh;
  assign win_any  = pick(bus.req, last_q);
  assign win_oth  = pick(others, last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
`ifdef MUX4_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
`ifdef MUX4_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
`ifdef MUX4_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = OWN;
          grant_d = 4'b0001 << win_any;
          sel_d   = win_any;
          last_d  = win_any;
`ifdef MUX4_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      OWN: begin
        if (bus.req[last_q]) begin
`ifdef MUX4_ARB_TIMEOUT_EN
          if (cnt_q == CW'(MAX_HOLD - 1)) begin
            cnt_d = '0;
            // Forced rotation: owner is excluded and must re-win later.
            if (|others) begin
              grant_d = 4'b0001 << win_oth;
              sel_d   = win_oth;
              last_d  = win_oth;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`endif
        end else if (|others) begin
          grant_d = 4'b0001 << win_oth;
          sel_d   = win_oth;
          last_d  = win_oth;
`ifdef MUX4_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = IDLE;
          grant_d = 4'b0000;
`ifdef MUX4_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.grant  = grant_q;
    bus.select = sel_q;
    bus.valid  = |grant_q;
  end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed bench for mux4_arbiter with MAX_HOLD=4; covers both macro builds.
module tb_mux4_arbiter;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  mux4_arbiter_if bus ();

  mux4_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant stays one-hot or zero, select tracks it, valid mirrors it.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("onehot0", 32'($onehot0(bus.grant)), 32'd1);
      chk("valid_eq", 32'(bus.valid), 32'(|bus.grant));
      if (bus.grant != 4'b0000)
        chk("sel_match", 32'(bus.grant[bus.select]), 32'd1);
    end
  end

  initial begin
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    tick();
    tick();
    mon_en = 1'b1;
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_valid", 32'(bus.valid), 32'h0);
    chk("rst_sel",   32'(bus.select), 32'h0);

    rst_n = 1'b1;
    tick();
    chk("first_grant", 32'(bus.grant), 32'h1);
    chk("first_sel",   32'(bus.select), 32'h0);

    // Rotation: each owner drops for one cycle in turn.
    bus.req = 4'b1110; tick(); chk("rot1", 32'(bus.grant), 32'h2); chk("rot1_sel", 32'(bus.select), 32'd1);
    bus.req = 4'b1101; tick(); chk("rot2", 32'(bus.grant), 32'h4); chk("rot2_sel", 32'(bus.select), 32'd2);
    bus.req = 4'b1011; tick(); chk("rot3", 32'(bus.grant), 32'h8); chk("rot3_sel", 32'(bus.select), 32'd3);
    bus.req = 4'b0111; tick(); chk("rot0", 32'(bus.grant), 32'h1); chk("rot0_sel", 32'(bus.select), 32'd0);

    bus.req = 4'b0000; tick();
    chk("rel_grant", 32'(bus.grant), 32'h0);
    chk("rel_valid", 32'(bus.valid), 32'h0);
    tick();
    chk("idle_sel", 32'(bus.select), 32'd0);

    // Single requester 2 for three cycles.
    bus.req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("single_grant", 32'(bus.grant), 32'h4);
      chk("single_sel",   32'(bus.select), 32'd2);
    end
    bus.req = 4'b0000; tick();
    chk("single_rel", 32'(bus.grant), 32'h0);
    chk("single_rel_valid", 32'(bus.valid), 32'h0);
    chk("single_keep_sel", 32'(bus.select), 32'd2);

`ifdef MUX4_ARB_TIMEOUT_EN
    // last=2: requester 0 wins first, then forced alternation every 4 cycles.
    bus.req = 4'b0011;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("timeout_alt", 32'(bus.grant), ((i / 4) % 2 == 0) ? 32'h1 : 32'h2);
    end
    bus.req = 4'b0000; tick();
    chk("timeout_rel", 32'(bus.grant), 32'h0);

    bus.req = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("solo_hold", 32'(bus.grant), 32'h8);
    end
    bus.req = 4'b0000; tick();
    chk("solo_rel", 32'(bus.grant), 32'h0);
`else
    // Without the timeout, owner 0 keeps the grant despite contention.
    bus.req = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("no_timeout", 32'(bus.grant), 32'h1);
    end
    bus.req = 4'b0000; tick();
    chk("no_timeout_rel", 32'(bus.grant), 32'h0);
`endif

    // Asynchronous reset in the middle of a grant, then clean restart.
    bus.req = 4'b0110; tick();
    chk("pre_rst_grant", 32'(bus.grant), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_grant", 32'(bus.grant), 32'h0);
    chk("async_rst_sel",   32'(bus.select), 32'h0);
    tick();
    bus.req = 4'b0010;
    rst_n   = 1'b1;
    tick();
    chk("post_rst_grant", 32'(bus.grant), 32'h2);
    chk("post_rst_sel",   32'(bus.select), 32'd1);
    bus.req = 4'b0000; tick();
    chk("post_rst_rel", 32'(bus.grant), 32'h0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux4_arbiter.md
# mux4_arbiter

Round-robin arbiter that shares the 4:1 single-bit multiplexer among four requesters. It samples request lines, grants exactly one requester at a time, and drives the mux `select` field so the granted input reaches the shared output. It sits directly in front of the mux4 datapath; `select` connects straight to the mux select port.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum consecutive cycles one requester holds the grant while others wait. Legal range is 2..256.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req`, input, 4: level request per requester; bit i belongs to requester i.
- `grant`, output, 4: one-hot grant, registered; all zeros when idle.
- `select`, output, 2: encoded index of the current or last owner; drives the mux select.
- `valid`, output, 1: high when `grant` is nonzero; the mux output is meaningful only then.

## Operation
- States: IDLE and OWN. A 2-bit `last` pointer holds the most recent owner.
- Winner search: scan requesters starting at `(last+1) mod 4` and wrapping; the first set `req` bit wins.
- IDLE:
  - `grant` = 0 and `valid` = 0; `select` keeps the last owner.
  - If any `req` bit is set, the winner is registered at the next edge: `grant`, `select` and `last` are loaded, `valid` goes to 1, and the state moves to OWN with the hold counter at 0.
- OWN, owner o:
  - If `req[o]` = 1 and there is no timeout, the grant is held and the hold counter increments.
  - If `req[o]` drops to 0 and another request is pending, the grant moves to the next winner on the same edge (no idle bubble) and the counter clears.
  - If `req[o]` drops to 0 and nothing else is pending, the state goes to IDLE with `grant` = 0.
  - Timeout: the counter equals `MAX_HOLD-1`, `req[o]` = 1, and another request is pending. The grant is forcibly moved to the next winner, excluding o; o must re-win through rotation.
  - If the counter reaches `MAX_HOLD-1` with no other request pending, o keeps the grant and the counter restarts at 0.
- Simultaneous requests are resolved only by rotation; there is no fixed priority.
- `grant` is never multi-hot. `grant[i]`=1 implies `select`==i.
- Hold counter width: clog2(`MAX_HOLD`); it never exceeds `MAX_HOLD-1`.

## Timing
- Reset (asynchronous, immediate): `grant`=0, `valid`=0, `select`=0, `last`=3 (so requester 0 has first priority), hold counter=0, state IDLE.
- Reset deassertion mid-grant: operation restarts from IDLE; there is no grant carry-over.
- Request-to-grant latency: 1 cycle. `req` sampled at edge n produces `grant` after edge n.
- Release latency: `req[o]` low at edge n means `grant[o]` is low after edge n; a handoff completes on the same edge.
- Maximum continuous ownership with contention: `MAX_HOLD` cycles.
- Worst-case wait for a requester holding `req` high: 3×`MAX_HOLD`+1 cycles.
- `select` changes only on the same edge where `grant` changes to a new owner. It never changes while `valid`=0.

## Configuration
- `MUX4_ARB_TIMEOUT_EN` defined:
  - The hold counter and forced rotation described above are compiled in.
- Not defined:
  - The counter logic is removed and `MAX_HOLD` is ignored.
  - The owner keeps the grant until its `req` drops.
  - The release and handoff rules are unchanged.

## Test plan
- Reset: hold `rst_n`=0 with `req`=4'b1111. Required: `grant`=0, `valid`=0, `select`=0. Release reset; one cycle later `grant`=4'b0001, `select`=0.
- Single requester: `req`=4'b0100 for 3 cycles, then 0. Required: `grant`=4'b0100 and `select`=2 from the cycle after request; IDLE with `grant`=0 one cycle after the drop.
- Rotation:
  - Setup: after requester 0 owns, all four request.
  - Stimulus: each owner drops for one cycle in turn.
  - Required: grant order 1, 2, 3, 0, with no idle bubbles between owners.
- Timeout (macro defined, `MAX_HOLD`=4): `req`=4'b0011 held constant. Required: owner 0 for 4 cycles, then owner 1 for 4, then 0, alternating.
- Timeout without contention (macro defined): `req`=4'b1000 for 20 cycles. Required: `grant`=4'b1000 continuously, with no gaps.
- Macro undefined: `req`=4'b0011 held for 20 cycles. Required: owner 0 for all 20 cycles. The test also asserts every cycle that `grant` is one-hot or zero and that `select` matches it.
